// File: rtl/vga_pkg.sv
// Shared definitions for the VGA image RAM path: default bus widths,
// the response tag carried alongside each RAM access, and the CPU request record.
package vga_pkg;

  localparam int VGA_ADDR_W = 18;
  localparam int VGA_DATA_W = 32;

  // Identifies who (if anyone) owns the read data returning from the RAM
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_CPU_RD = 2'd2
  } tag_t;

  // One buffered processor load/store request
  typedef struct packed {
    logic                  we;
    logic [VGA_ADDR_W-1:0] addr;
    logic [VGA_DATA_W-1:0] wdata;
  } cpu_req_t;

endpackage

// File: rtl/req_fifo.sv
// Small synchronous FIFO holding queued CPU requests.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
module req_fifo #(
  parameter int WIDTH = 51,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign dout  = mem[rd_ptr[IDX_W-1:0]];

  // Advance read/write pointers; reset discards everything queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array needs no reset since the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
  end

endmodule

// File: rtl/image_ram_arbiter.sv
// Shares the single-port image RAM between the display fetcher and the CPU.
// Display reads always win; CPU requests queue in order and use idle cycles.
module image_ram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = VGA_ADDR_W,
  parameter int DATA_W       = VGA_DATA_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int RAM_LAT      = 1,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_starve,
  output logic [15:0]       starve_cnt
);

  localparam int          REQ_W     = 1 + ADDR_W + DATA_W;
  localparam logic [15:0] STARVE_TH = 16'(STARVE_LIMIT);

  logic              ready_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [REQ_W-1:0]  push_word;
  logic [REQ_W-1:0]  head_word;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;
  logic [ADDR_W-1:0] last_addr;
  tag_t              issue_tag;
  tag_t              tag_pipe [RAM_LAT];

  // ready_q keeps the CPU port closed while in reset and for the release cycle
  assign cpu_ready = ready_q && !fifo_full;
  assign push      = cpu_valid && cpu_ready;
  assign push_word = {cpu_we, cpu_addr, cpu_wdata};
  assign {head_we, head_addr, head_wdata} = head_word;
  assign pop       = !disp_req && !fifo_empty;

  req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_word),
    .pop   (pop),
    .dout  (head_word),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pick this cycle's RAM access: display first, else FIFO head, else hold address
  always_comb begin
    ram_addr  = last_addr;
    ram_we    = 1'b0;
    ram_wdata = head_wdata;
    issue_tag = TAG_NONE;
    if (disp_req) begin
      ram_addr  = disp_addr;
      issue_tag = TAG_DISP;
    end else if (!fifo_empty) begin
      ram_addr  = head_addr;
      ram_we    = head_we;
      issue_tag = head_we ? TAG_NONE : TAG_CPU_RD;
    end
  end

  // Open the CPU port one cycle after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Remember the last driven address so an idle RAM sees a stable bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_addr <= '0;
    else      last_addr <= ram_addr;
  end

  // Tag shift register matching the RAM read latency; reset drops in-flight reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAM_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < RAM_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign disp_rvalid = (tag_pipe[RAM_LAT-1] == TAG_DISP);
  assign cpu_rvalid  = (tag_pipe[RAM_LAT-1] == TAG_CPU_RD);
  assign disp_rdata  = ram_rdata;
  assign cpu_rdata   = ram_rdata;

  // Count consecutive cycles a queued CPU request is blocked by the display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (disp_req && (starve_cnt != 16'hFFFF)) begin
      starve_cnt <= starve_cnt + 16'd1;
    end
  end

  // Registered starvation flag derived from the counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cpu_starve <= 1'b0;
    else      cpu_starve <= (starve_cnt >= STARVE_TH);
  end

endmodule

// File: tb/tb_image_ram_arbiter.sv
// Self-checking bench for image_ram_arbiter with a behavioural RAM of latency RAM_LAT.
// Read responses are scoreboarded: expectations are queued when a request is driven
// and popped by a monitor whenever the DUT raises a read-valid.
module tb_image_ram_arbiter;
  import vga_pkg::*;

  localparam int RAM_LAT      = 2;
  localparam int STARVE_LIMIT = 8;
  localparam int FIFO_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [17:0] disp_addr;
  logic        disp_rvalid;
  logic [31:0] disp_rdata;
  logic        cpu_valid;
  logic        cpu_ready;
  logic        cpu_we;
  logic [17:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic [17:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        cpu_starve;
  logic [15:0] starve_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int cpu_resp_cnt = 0;
  int cpu_last_cyc = 0;

  logic [31:0] disp_exp_q [$];
  logic [31:0] cpu_exp_q  [$];
  logic [31:0] model_mem  [1024];

  typedef struct {
    logic [17:0] addr;
    logic [31:0] exp_data;
  } disp_vec_t;
  disp_vec_t disp_tab [8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  image_ram_arbiter #(
    .ADDR_W       (18),
    .DATA_W       (32),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .RAM_LAT      (RAM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .cpu_valid   (cpu_valid),
    .cpu_ready   (cpu_ready),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .cpu_starve  (cpu_starve),
    .starve_cnt  (starve_cnt)
  );

  // Behavioural single-port RAM: preloaded with addr*3, read data RAM_LAT cycles after the address
  logic [31:0] ram_mem [1024];
  logic [31:0] rd_pipe [RAM_LAT];
  logic        preloaded = 1'b0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= 32'(i * 3);
      preloaded <= 1'b1;
    end else if (ram_we) begin
      ram_mem[ram_addr[9:0]] <= ram_wdata;
    end
    rd_pipe[0] <= ram_mem[ram_addr[9:0]];
    for (int i = 1; i < RAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = rd_pipe[RAM_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic dreq, input logic [17:0] daddr, input logic cvalid,
                               input logic cwe, input logic [17:0] caddr, input logic [31:0] cdata);
    disp_req  = dreq;
    disp_addr = daddr;
    cpu_valid = cvalid;
    cpu_we    = cwe;
    cpu_addr  = caddr;
    cpu_wdata = cdata;
  endtask

  // Drive one display read and queue its expected data
  task automatic dispRead(input logic [17:0] addr);
    disp_req  = 1'b1;
    disp_addr = addr;
    disp_exp_q.push_back(model_mem[addr[9:0]]);
  endtask

  // Issue one CPU request, waiting (bounded) for acceptance; updates the model in order
  task automatic cpuAccess(input logic we, input logic [17:0] addr, input logic [31:0] data);
    bit acc = 1'b0;
    cpu_valid = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (cpu_ready) begin
        acc = 1'b1;
        if (we) model_mem[addr[9:0]] = data;
        else    cpu_exp_q.push_back(model_mem[addr[9:0]]);
      end
      step();
    end
    cpu_valid = 1'b0;
    checkOutput("cpu_accept", 64'(acc), 64'd1);
  endtask

  // Response monitor: every read-valid must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (disp_rvalid) begin
      if (disp_exp_q.size() == 0) checkOutput("disp_unexpected_rvalid", 64'd1, 64'd0);
      else checkOutput("disp_rdata", 64'(disp_rdata), 64'(disp_exp_q.pop_front()));
    end
    if (cpu_rvalid) begin
      cpu_resp_cnt++;
      cpu_last_cyc = cyc;
      if (cpu_exp_q.size() == 0) checkOutput("cpu_unexpected_rvalid", 64'd1, 64'd0);
      else checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(cpu_exp_q.pop_front()));
    end
  end

  initial begin
    int base;
    int issue_cyc;
    int k;
    bit acc_now;
    logic [15:0] rv_bits;

    for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i * 3);
    for (int i = 0; i < 8; i++) begin
      disp_tab[i].addr     = 18'(i);
      disp_tab[i].exp_data = 32'(i * 3);
    end

    // ---- Reset then idle ----
    rst = 1'b0;
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 32'd0);
    step();
    step();
    @(negedge clk);
    checkOutput("reset_cpu_ready", 64'(cpu_ready), 64'd0);
    checkOutput("reset_ram_we", 64'(ram_we), 64'd0);
    checkOutput("reset_valids", 64'({disp_rvalid, cpu_rvalid}), 64'd0);
    checkOutput("reset_starve", 64'({cpu_starve, starve_cnt}), 64'd0);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    checkOutput("release_cpu_ready", 64'(cpu_ready), 64'd1);
    checkOutput("idle_ram_we", 64'(ram_we), 64'd0);
    step();

    // ---- Display only: table-driven, data = addr*3, latency RAM_LAT ----
    rv_bits = '0;
    for (int j = 0; j < 12; j++) begin
      if (j < 8) dispRead(disp_tab[j].addr);
      else       disp_req = 1'b0;
      @(negedge clk);
      rv_bits[j] = disp_rvalid;
      if (j < 8) begin
        checkOutput("disp_ram_addr", 64'(ram_addr), 64'(disp_tab[j].addr));
        checkOutput("disp_exp_table", 64'(model_mem[disp_tab[j].addr[9:0]]), 64'(disp_tab[j].exp_data));
      end
      step();
    end
    checkOutput("disp_rvalid_window", 64'(rv_bits), 64'(16'h00FF << RAM_LAT));

    // ---- CPU in blanking: write then read same address ----
    base = cpu_resp_cnt;
    checkOutput("blank_cpu_ready", 64'(cpu_ready), 64'd1);
    applyStimulus(1'b0, 18'd0, 1'b1, 1'b1, 18'h100, 32'hDEADBEEF);
    model_mem[10'h100] = 32'hDEADBEEF;
    step();
    cpu_we = 1'b0;
    cpu_exp_q.push_back(model_mem[10'h100]);
    @(negedge clk);
    checkOutput("blank_write_issue", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 18'h100, 32'hDEADBEEF}));
    step();
    cpu_valid = 1'b0;
    @(negedge clk);
    checkOutput("blank_read_issue", 64'({ram_we, ram_addr}), 64'({1'b0, 18'h100}));
    issue_cyc = cyc;
    for (int j = 0; j < 6; j++) step();
    checkOutput("blank_read_resp_count", 64'(cpu_resp_cnt - base), 64'd1);
    checkOutput("blank_read_latency", 64'(cpu_last_cyc - issue_cyc), 64'(RAM_LAT));
    @(negedge clk);
    checkOutput("idle_addr_hold", 64'({ram_we, ram_addr}), 64'({1'b0, 18'h100}));
    step();

    // ---- Contention and full: display busy while pushing 5 writes ----
    k = 0;
    cpu_valid = 1'b1;
    cpu_we    = 1'b1;
    for (int j = 0; j < 7; j++) begin
      dispRead(18'(32 + j));
      cpu_addr  = 18'(18'h200 + k);
      cpu_wdata = 32'hA000_0000 + 32'(k);
      acc_now   = cpu_ready;
      @(negedge clk);
      checkOutput("contend_disp_wins", 64'({ram_we, ram_addr}), 64'({1'b0, 18'(32 + j)}));
      step();
      if (acc_now) begin
        model_mem[10'h200 + 10'(k)] = 32'hA000_0000 + 32'(k);
        k++;
      end
    end
    checkOutput("contend_accepted", 64'(k), 64'(FIFO_DEPTH));
    checkOutput("contend_full_ready", 64'(cpu_ready), 64'd0);
    disp_req  = 1'b0;
    cpu_addr  = 18'h204;
    cpu_wdata = 32'hA000_0004;
    for (int j = 0; j < 5; j++) begin
      acc_now = cpu_valid && cpu_ready;
      @(negedge clk);
      checkOutput("drain_write_issue", 64'({ram_we, ram_addr, ram_wdata}),
                  64'({1'b1, 18'(18'h200 + j), 32'hA000_0000 + 32'(j)}));
      step();
      if (acc_now) begin
        model_mem[10'h204] = 32'hA000_0004;
        k++;
        cpu_valid = 1'b0;
      end
    end
    checkOutput("contend_fifth_accepted", 64'(k), 64'd5);
    cpuAccess(1'b0, 18'h204, 32'd0);
    cpuAccess(1'b0, 18'h201, 32'd0);
    for (int j = 0; j < 6; j++) step();

    // ---- Starvation: one queued read blocked by the display ----
    dispRead(18'd40);
    applyStimulus(1'b1, 18'd40, 1'b1, 1'b0, 18'd5, 32'd0);
    cpu_exp_q.push_back(model_mem[5]);
    step();
    cpu_valid = 1'b0;
    for (int j = 0; j < 10; j++) begin
      dispRead(18'(41 + j));
      @(negedge clk);
      checkOutput("starve_cnt", 64'(starve_cnt), 64'(j));
      checkOutput("starve_flag", 64'(cpu_starve), 64'(j >= 9));
      step();
    end
    disp_req = 1'b0;
    @(negedge clk);
    checkOutput("starve_peak", 64'({cpu_starve, starve_cnt}), 64'({1'b1, 16'd10}));
    checkOutput("starve_pop_issue", 64'({ram_we, ram_addr}), 64'({1'b0, 18'd5}));
    step();
    @(negedge clk);
    checkOutput("starve_cnt_cleared", 64'({cpu_starve, starve_cnt}), 64'({1'b1, 16'd0}));
    step();
    @(negedge clk);
    checkOutput("starve_flag_cleared", 64'({cpu_starve, starve_cnt}), 64'd0);
    for (int j = 0; j < 6; j++) step();

    // ---- Reset mid-flight: one read in flight, two queued, none may respond ----
    base = cpu_resp_cnt;
    applyStimulus(1'b0, 18'd0, 1'b1, 1'b0, 18'h010, 32'd0);
    step();
    cpu_addr = 18'h011;
    step();
    disp_req = 1'b1;
    cpu_addr = 18'h012;
    step();
    applyStimulus(1'b0, 18'd0, 1'b0, 1'b0, 18'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_cpu_ready", 64'(cpu_ready), 64'd0);
    step();
    step();
    rst = 1'b1;
    for (int j = 0; j < 6; j++) step();
    @(negedge clk);
    checkOutput("midreset_no_resp", 64'(cpu_resp_cnt - base), 64'd0);
    checkOutput("midreset_ready", 64'(cpu_ready), 64'd1);
    checkOutput("midreset_fifo_empty", 64'({ram_we, starve_cnt}), 64'd0);
    step();
    cpuAccess(1'b0, 18'd7, 32'd0);
    for (int j = 0; j < 6; j++) step();
    checkOutput("post_reset_single_resp", 64'(cpu_resp_cnt - base), 64'd1);

    checkOutput("disp_queue_drained", 64'(disp_exp_q.size()), 64'd0);
    checkOutput("cpu_queue_drained", 64'(cpu_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
